// File: rtl/servo_angle_ctrl_pkg.sv
// Shared constants and FSM state encoding for the servo angle controller.
// Optional feature: SERVO_ANGLE_WRAP_EN (handled in servo_angle_ctrl.sv).
package servo_pkg;

   // Defaults for a 50 MHz system clock
   localparam int unsigned DEF_DEB_CYC  = 1000000;  // 20 ms key settle time
   localparam int unsigned DEF_SLEW_CYC = 500000;   // 10 ms per degree
   localparam int unsigned DEF_STEP_DEG = 10;       // degrees per key press
   localparam int unsigned DEF_MAX_DEG  = 180;      // upper angle limit (1..255)

   // Slew FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_UP   = 2'b01,
      ST_DOWN = 2'b10
   } servo_state_e;

endpackage

// File: rtl/servo_angle_ctrl_if.sv
// Key inputs and angle outputs of the servo angle controller.
// The controller takes the slave side; the key/PWM side takes the master side.
interface servo_angle_ctrl_if;
   logic       key1;    // raw increment key, active low
   logic       key2;    // raw decrement key, active low
   logic [7:0] angle;   // slewed angle, degrees
   logic [7:0] target;  // commanded angle, degrees
   logic       moving;  // angle != target

   modport master (output key1, key2, input  angle, target, moving);
   modport slave  (input  key1, key2, output angle, target, moving);
endinterface

// File: rtl/servo_angle_ctrl_key_debounce.sv
// Per-key conditioning: 2-flop synchronizer, counter debounce, press-edge
// detect. Keys are active low; a press event is a one-cycle pulse on the
// debounced 1->0 transition. Releases produce nothing.
module key_debounce
   import servo_pkg::*;
#(
   parameter int unsigned DEB_CYC = DEF_DEB_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic press_o
);

   localparam int unsigned CW = $clog2(DEB_CYC + 1);

   logic [1:0]    sync_q;
   logic          deb_q, deb_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchronize the raw key; idles at the released level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b11;
      else        sync_q <= {sync_q[0], key_i};
   end

   // Count consecutive cycles the synced level disagrees with the debounced
   // level; any agreement (bounce) restarts the count from zero
   always_comb begin
      deb_d   = deb_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (sync_q[1] != deb_q) begin
         if (cnt_q == CW'(DEB_CYC - 1)) begin
            deb_d   = sync_q[1];
            press_d = deb_q;     // leaving the released (1) level = press
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q   <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/servo_angle_ctrl.sv
// Two-key servo angle controller: keys step a target angle, and the output
// angle slews toward it one degree per SLEW_CYC cycles.
// Optional feature: define SERVO_ANGLE_WRAP_EN to make the target wrap
// (past MAX_DEG -> 0, below 0 -> MAX_DEG) instead of saturating.
module servo_angle_ctrl
   import servo_pkg::*;
#(
   parameter int unsigned DEB_CYC  = DEF_DEB_CYC,
   parameter int unsigned SLEW_CYC = DEF_SLEW_CYC,
   parameter int unsigned STEP_DEG = DEF_STEP_DEG,
   parameter int unsigned MAX_DEG  = DEF_MAX_DEG
) (
   input  logic               clk,
   input  logic               rst_n,
   servo_angle_ctrl_if.slave  bus
);

   localparam int unsigned SW = $clog2(SLEW_CYC + 1);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_UP   = ST_UP;
   localparam logic [1:0] S_DOWN = ST_DOWN;

`ifdef SERVO_ANGLE_WRAP_EN
   localparam logic [7:0] OVF_VAL = 8'd0;
   localparam logic [7:0] UNF_VAL = 8'(MAX_DEG);
`else
   localparam logic [7:0] OVF_VAL = 8'(MAX_DEG);
   localparam logic [7:0] UNF_VAL = 8'd0;
`endif

   logic          inc_ev, dec_ev;
   logic [7:0]    target_q, target_d;
   logic [7:0]    angle_q, angle_d;
   logic [1:0]    state_q, state_d;
   logic [SW-1:0] slew_q, slew_d;
   logic [8:0]    sum9;

   key_debounce #(.DEB_CYC(DEB_CYC)) u_key_inc (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_i   (bus.key1),
      .press_o (inc_ev)
   );

   key_debounce #(.DEB_CYC(DEB_CYC)) u_key_dec (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_i   (bus.key2),
      .press_o (dec_ev)
   );

   // 9-bit sum so target+STEP_DEG cannot wrap before the limit compare
   assign sum9 = {1'b0, target_q} + 9'(STEP_DEG);

   // Target stepping; simultaneous inc and dec cancel out
   always_comb begin
      target_d = target_q;
      if (inc_ev && !dec_ev) begin
         if (sum9 > 9'(MAX_DEG)) target_d = OVF_VAL;
         else                    target_d = sum9[7:0];
      end else if (dec_ev && !inc_ev) begin
         if ({1'b0, target_q} < 9'(STEP_DEG)) target_d = UNF_VAL;
         else                                 target_d = target_q - 8'(STEP_DEG);
      end
   end

   // Slew FSM: leave IDLE with a cleared counter; at each tick pick the
   // direction from the current target so mid-ramp reversals go straight
   // UP<->DOWN and a step never passes the target
   always_comb begin
      state_d = state_q;
      angle_d = angle_q;
      slew_d  = slew_q;
      case (state_q)
         S_IDLE: begin
            slew_d = '0;
            if (target_q > angle_q)      state_d = S_UP;
            else if (target_q < angle_q) state_d = S_DOWN;
         end
         S_UP, S_DOWN: begin
            if (angle_q == target_q) begin
               state_d = S_IDLE;
               slew_d  = '0;
            end else if (slew_q == SW'(SLEW_CYC - 1)) begin
               slew_d = '0;
               if (target_q > angle_q) begin
                  state_d = S_UP;
                  angle_d = angle_q + 8'd1;
               end else begin
                  state_d = S_DOWN;
                  angle_d = angle_q - 8'd1;
               end
            end else begin
               slew_d = slew_q + SW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            slew_d  = '0;
         end
      endcase
   end

   // Controller state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q <= 8'd0;
         angle_q  <= 8'd0;
         state_q  <= S_IDLE;
         slew_q   <= '0;
      end else begin
         target_q <= target_d;
         angle_q  <= angle_d;
         state_q  <= state_d;
         slew_q   <= slew_d;
      end
   end

   assign bus.angle  = angle_q;
   assign bus.target = target_q;
   assign bus.moving = (angle_q != target_q);

endmodule
